button_event_generator: RTL and testbench

Input-side conditioner for the four active-low DE0-CV push buttons. It turns the raw, bouncy, asynchronous button levels into clean events in the in_clk domain: a debounced level, a one-cycle press pulse, a one-cycle release pulse, and optional auto-repeat pulses. It sits between the board pins and the up/down/reset consumers (state machine, counters), so those consumers are clocked only by in_clk and never by button edges.

---
 rtl/button_event_generator.sv | 186 ++++++++++++++++++
 tb/tb_button_event_generator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_generator.sv
// -----------------------------------------------------------------------------
// button_event_generator
//
// Conditions the four active-low DE0-CV push buttons into clean in_clk-domain
// events. Each button goes through a two-flop synchronizer and then its own
// four-state debounce FSM (RELEASED / PRESS_CHK / HELD / RELEASE_CHK), which
// has a 26-bit debounce counter and a 26-bit auto-repeat counter.
//
// Ports:
//   in_clk         system clock (50 MHz)
//   global_reset   asynchronous, active-high reset
//   in_button[3:0] raw buttons, active-low, asynchronous to in_clk
//   out_level      debounced level, 1 = held
//   out_press      one-cycle pulse when a press is accepted
//   out_release    one-cycle pulse when a release is accepted
//   out_repeat     one-cycle auto-repeat pulse while held (REPEAT_MASK bits)
//   out_any_press  OR of every out_press and out_repeat bit
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module button_event_generator #(
  parameter logic [25:0] DEBOUNCE_CYCLES = 26'd1_000_000,
  parameter logic [25:0] REPEAT_DELAY    = 26'd25_000_000,
  parameter logic [25:0] REPEAT_PERIOD   = 26'd10_000_000,
  parameter logic [3:0]  REPEAT_MASK     = 4'b0110
) (
  input  logic       in_clk,
  input  logic       global_reset,
  input  logic [3:0] in_button,
  output logic [3:0] out_level,
  output logic [3:0] out_press,
  output logic [3:0] out_release,
  output logic [3:0] out_repeat,
  output logic       out_any_press
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  localparam logic [25:0] DEBOUNCE_LAST = DEBOUNCE_CYCLES - 26'd1;
  localparam logic [25:0] DELAY_LAST    = REPEAT_DELAY - 26'd1;
  localparam logic [25:0] PERIOD_LAST   = REPEAT_PERIOD - 26'd1;

  // Synchronizer stages hold raw (active-low) levels; reset value means released.
  logic [3:0]  sync1_r;
  logic [3:0]  sync2_r;
  logic [3:0]  pressed_s;

  btn_state_t  state_r      [4];
  btn_state_t  state_nxt_s  [4];
  logic [25:0] dcnt_r       [4];
  logic [25:0] dcnt_nxt_s   [4];
  logic [25:0] rcnt_r       [4];
  logic [25:0] rcnt_nxt_s   [4];
  logic [25:0] rcnt_cmp_s   [4];
  logic [3:0]  first_done_r;
  logic [3:0]  first_done_nxt_s;

  logic [3:0]  level_s;
  logic [3:0]  press_s;
  logic [3:0]  release_s;
  logic [3:0]  repeat_s;

  assign pressed_s = ~sync2_r;

  // Per-button next-state, counter and pulse decode.
  always_comb begin
    first_done_nxt_s = first_done_r;
    level_s          = 4'b0000;
    press_s          = 4'b0000;
    release_s        = 4'b0000;
    repeat_s         = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      state_nxt_s[n] = state_r[n];
      dcnt_nxt_s[n]  = dcnt_r[n];
      rcnt_nxt_s[n]  = rcnt_r[n];
      // The first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
      if (first_done_r[n]) begin
        rcnt_cmp_s[n] = PERIOD_LAST;
      end else begin
        rcnt_cmp_s[n] = DELAY_LAST;
      end

      case (state_r[n])
        RELEASED: begin
          if (pressed_s[n]) begin
            state_nxt_s[n] = PRESS_CHK;
            dcnt_nxt_s[n]  = 26'd0;
          end else begin
            state_nxt_s[n] = RELEASED;
          end
        end

        PRESS_CHK: begin
          if (!pressed_s[n]) begin
            // Bounce: drop back without any event.
            state_nxt_s[n] = RELEASED;
          end else if (dcnt_r[n] == DEBOUNCE_LAST) begin
            state_nxt_s[n]      = HELD;
            press_s[n]          = 1'b1;
            rcnt_nxt_s[n]       = 26'd0;
            first_done_nxt_s[n] = 1'b0;
          end else begin
            dcnt_nxt_s[n] = dcnt_r[n] + 26'd1;
          end
        end

        HELD: begin
          if (!pressed_s[n]) begin
            // rcnt is frozen so a release bounce resumes the repeat cadence.
            state_nxt_s[n] = RELEASE_CHK;
            dcnt_nxt_s[n]  = 26'd0;
          end else if (REPEAT_MASK[n]) begin
            if (rcnt_r[n] == rcnt_cmp_s[n]) begin
              repeat_s[n]         = 1'b1;
              rcnt_nxt_s[n]       = 26'd0;
              first_done_nxt_s[n] = 1'b1;
            end else begin
              rcnt_nxt_s[n] = rcnt_r[n] + 26'd1;
            end
          end else begin
            rcnt_nxt_s[n] = rcnt_r[n];
          end
        end

        RELEASE_CHK: begin
          if (pressed_s[n]) begin
            state_nxt_s[n] = HELD;
          end else if (dcnt_r[n] == DEBOUNCE_LAST) begin
            state_nxt_s[n] = RELEASED;
            release_s[n]   = 1'b1;
          end else begin
            dcnt_nxt_s[n] = dcnt_r[n] + 26'd1;
          end
        end

        default: begin
          state_nxt_s[n] = RELEASED;
          dcnt_nxt_s[n]  = 26'd0;
          rcnt_nxt_s[n]  = 26'd0;
        end
      endcase

      // Registered level follows the state being entered.
      level_s[n] = (state_nxt_s[n] == HELD) || (state_nxt_s[n] == RELEASE_CHK);
    end
  end

  // Synchronizer, FSM state, counters and registered outputs.
  always_ff @(posedge in_clk or posedge global_reset) begin
    if (global_reset) begin
      sync1_r       <= 4'b1111;
      sync2_r       <= 4'b1111;
      first_done_r  <= 4'b0000;
      out_level     <= 4'b0000;
      out_press     <= 4'b0000;
      out_release   <= 4'b0000;
      out_repeat    <= 4'b0000;
      out_any_press <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        state_r[n] <= RELEASED;
        dcnt_r[n]  <= 26'd0;
        rcnt_r[n]  <= 26'd0;
      end
    end else begin
      sync1_r       <= in_button;
      sync2_r       <= sync1_r;
      first_done_r  <= first_done_nxt_s;
      out_level     <= level_s;
      out_press     <= press_s;
      out_release   <= release_s;
      out_repeat    <= repeat_s;
      out_any_press <= |(press_s | repeat_s);
      for (int n = 0; n < 4; n++) begin
        state_r[n] <= state_nxt_s[n];
        dcnt_r[n]  <= dcnt_nxt_s[n];
        rcnt_r[n]  <= rcnt_nxt_s[n];
      end
    end
  end

endmodule

// File: tb/tb_button_event_generator.sv
// -----------------------------------------------------------------------------
// tb_button_event_generator
//
// Self-checking bench for button_event_generator with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_MASK=4'b0110. Each scenario task
// pushes the events it expects (edge number + pulse bits) into a scoreboard
// queue while it drives buttons, and every cycle pops what is due and
// compares the full output vector {level, press, release, repeat, any}.
// Input driven at a negedge is sampled by the next posedge; outputs are
// sampled at negedges, after the posedge counted in edge_cnt.
// -----------------------------------------------------------------------------
module tb_button_event_generator;

  logic       in_clk;
  logic       global_reset;
  logic [3:0] in_button;
  logic [3:0] out_level;
  logic [3:0] out_press;
  logic [3:0] out_release;
  logic [3:0] out_repeat;
  logic       out_any_press;

  button_event_generator #(
    .DEBOUNCE_CYCLES(26'd4),
    .REPEAT_DELAY   (26'd10),
    .REPEAT_PERIOD  (26'd3),
    .REPEAT_MASK    (4'b0110)
  ) dut (
    .in_clk       (in_clk),
    .global_reset (global_reset),
    .in_button    (in_button),
    .out_level    (out_level),
    .out_press    (out_press),
    .out_release  (out_release),
    .out_repeat   (out_repeat),
    .out_any_press(out_any_press)
  );

  typedef struct {
    int         edge_n;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rep;
  } ev_t;

  ev_t         sb_q[$];
  logic [3:0]  exp_level;
  int          edge_cnt;
  int          check_cnt;
  int          err_cnt;
  logic [16:0] got_vec;
  logic [16:0] exp_vec;

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) edge_cnt <= edge_cnt + 1;

  function automatic void push_ev(input int e, input logic [3:0] p,
                                  input logic [3:0] r, input logic [3:0] t);
    ev_t ev;
    ev.edge_n = e;
    ev.press  = p;
    ev.rel    = r;
    ev.rep    = t;
    sb_q.push_back(ev);
  endfunction

  // Pushes repeat pulses for bits b at edges first, first+step, ... <= last.
  function automatic void push_repeats(input int first, input int last,
                                       input int step, input logic [3:0] b);
    for (int e = first; e <= last; e += step) push_ev(e, 4'b0000, 4'b0000, b);
  endfunction

  // Pops every event due at edge e and forms the expected output vector.
  task automatic sb_pop(input int e, output logic [16:0] v);
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] t;
    p = 4'b0000;
    r = 4'b0000;
    t = 4'b0000;
    for (int k = sb_q.size() - 1; k >= 0; k--) begin
      if (sb_q[k].edge_n == e) begin
        p = p | sb_q[k].press;
        r = r | sb_q[k].rel;
        t = t | sb_q[k].rep;
        sb_q.delete(k);
      end
    end
    exp_level = (exp_level | p) & ~r;
    v = {exp_level, p, r, t, |(p | t)};
  endtask

  task automatic test_reset();
    global_reset = 1'b1;
    in_button    = 4'b1111;
    exp_level    = 4'b0000;
    repeat (3) @(negedge in_clk);
    got_vec = {out_level, out_press, out_release, out_repeat, out_any_press};
    check_cnt++;
    if (got_vec !== 17'd0) begin
      err_cnt++;
      $display("FAIL reset_state: got %h expected %h", got_vec, 17'd0);
    end
    global_reset = 1'b0;
    repeat (2) @(negedge in_clk);
  endtask

  // Button 2 held 40 cycles: press at +6, repeats at +16,+19,...
  task automatic test_clean_press();
    int e0;
    e0 = edge_cnt + 1;
    push_ev(e0 + 6, 4'b0100, 4'b0000, 4'b0000);
    push_repeats(e0 + 16, e0 + 40, 3, 4'b0100);
    push_ev(e0 + 46, 4'b0000, 4'b0100, 4'b0000);
    for (int t = 0; t < 50; t++) begin
      sb_pop(edge_cnt, exp_vec);
      got_vec = {out_level, out_press, out_release, out_repeat, out_any_press};
      check_cnt++;
      if (got_vec !== exp_vec) begin
        err_cnt++;
        $display("FAIL clean_press edge %0d: got %h expected %h", edge_cnt - e0, got_vec, exp_vec);
      end
      in_button = (t < 40) ? 4'b1011 : 4'b1111;
      @(negedge in_clk);
    end
  endtask

  // Button 1: 3-cycle burst, 2 released, then stable press from t=5.
  task automatic test_press_bounce();
    int e0;
    e0 = edge_cnt + 1;
    push_ev(e0 + 11, 4'b0010, 4'b0000, 4'b0000);
    push_repeats(e0 + 21, e0 + 27, 3, 4'b0010);
    push_ev(e0 + 32, 4'b0000, 4'b0010, 4'b0000);
    for (int t = 0; t < 36; t++) begin
      sb_pop(edge_cnt, exp_vec);
      got_vec = {out_level, out_press, out_release, out_repeat, out_any_press};
      check_cnt++;
      if (got_vec !== exp_vec) begin
        err_cnt++;
        $display("FAIL press_bounce edge %0d: got %h expected %h", edge_cnt - e0, got_vec, exp_vec);
      end
      in_button = ((t < 3) || (t >= 5 && t < 26)) ? 4'b1101 : 4'b1111;
      @(negedge in_clk);
    end
  endtask

  // Button 2 released for 2 cycles while held; repeat resumes from frozen rcnt.
  task automatic test_release_bounce();
    int e0;
    e0 = edge_cnt + 1;
    push_ev(e0 + 6, 4'b0100, 4'b0000, 4'b0000);
    push_repeats(e0 + 16, e0 + 19, 3, 4'b0100);
    push_repeats(e0 + 25, e0 + 37, 3, 4'b0100);
    push_ev(e0 + 42, 4'b0000, 4'b0100, 4'b0000);
    for (int t = 0; t < 46; t++) begin
      sb_pop(edge_cnt, exp_vec);
      got_vec = {out_level, out_press, out_release, out_repeat, out_any_press};
      check_cnt++;
      if (got_vec !== exp_vec) begin
        err_cnt++;
        $display("FAIL release_bounce edge %0d: got %h expected %h", edge_cnt - e0, got_vec, exp_vec);
      end
      in_button = ((t < 20) || (t >= 22 && t < 36)) ? 4'b1011 : 4'b1111;
      @(negedge in_clk);
    end
  endtask

  // Button 3 has repeat masked off: press, no repeats, release.
  task automatic test_masked_hold();
    int e0;
    e0 = edge_cnt + 1;
    push_ev(e0 + 6, 4'b1000, 4'b0000, 4'b0000);
    push_ev(e0 + 56, 4'b0000, 4'b1000, 4'b0000);
    for (int t = 0; t < 60; t++) begin
      sb_pop(edge_cnt, exp_vec);
      got_vec = {out_level, out_press, out_release, out_repeat, out_any_press};
      check_cnt++;
      if (got_vec !== exp_vec) begin
        err_cnt++;
        $display("FAIL masked_hold edge %0d: got %h expected %h", edge_cnt - e0, got_vec, exp_vec);
      end
      in_button = (t < 50) ? 4'b0111 : 4'b1111;
      @(negedge in_clk);
    end
  endtask

  // Buttons 1 and 2 pressed on the same edge.
  task automatic test_simultaneous();
    int e0;
    e0 = edge_cnt + 1;
    push_ev(e0 + 6, 4'b0110, 4'b0000, 4'b0000);
    push_repeats(e0 + 16, e0 + 19, 3, 4'b0110);
    push_ev(e0 + 26, 4'b0000, 4'b0110, 4'b0000);
    for (int t = 0; t < 30; t++) begin
      sb_pop(edge_cnt, exp_vec);
      got_vec = {out_level, out_press, out_release, out_repeat, out_any_press};
      check_cnt++;
      if (got_vec !== exp_vec) begin
        err_cnt++;
        $display("FAIL simultaneous edge %0d: got %h expected %h", edge_cnt - e0, got_vec, exp_vec);
      end
      in_button = (t < 20) ? 4'b1001 : 4'b1111;
      @(negedge in_clk);
    end
  endtask

  // Reset mid-HELD on button 2 for 5 cycles; re-debounce after deassert.
  task automatic test_reset_mid_hold();
    int e0;
    e0 = edge_cnt + 1;
    push_ev(e0 + 6, 4'b0100, 4'b0000, 4'b0000);
    // Reset released before edge e0+17: press after that edge + 6.
    push_ev(e0 + 23, 4'b0100, 4'b0000, 4'b0000);
    push_repeats(e0 + 33, e0 + 39, 3, 4'b0100);
    push_ev(e0 + 46, 4'b0000, 4'b0100, 4'b0000);
    for (int t = 0; t < 50; t++) begin
      sb_pop(edge_cnt, exp_vec);
      got_vec = {out_level, out_press, out_release, out_repeat, out_any_press};
      check_cnt++;
      if (got_vec !== exp_vec) begin
        err_cnt++;
        $display("FAIL reset_mid_hold edge %0d: got %h expected %h", edge_cnt - e0, got_vec, exp_vec);
      end
      in_button = (t < 40) ? 4'b1011 : 4'b1111;
      if (t == 17) global_reset = 1'b0;
      if (t == 12) begin
        #2;
        global_reset = 1'b1;
        exp_level    = 4'b0000;
        #1;
        got_vec = {out_level, out_press, out_release, out_repeat, out_any_press};
        check_cnt++;
        if (got_vec !== 17'd0) begin
          err_cnt++;
          $display("FAIL async_reset_clear: got %h expected %h", got_vec, 17'd0);
        end
      end
      @(negedge in_clk);
    end
    check_cnt++;
    if (sb_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drained: got %0d pending expected 0", sb_q.size());
    end
  endtask

  initial begin
    edge_cnt     = 0;
    check_cnt    = 0;
    err_cnt      = 0;
    exp_level    = 4'b0000;
    global_reset = 1'b1;
    in_button    = 4'b1111;
    @(negedge in_clk);
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_masked_hold();
    test_simultaneous();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
